// File: rtl/product_accumulator.sv
// Saturating sum-of-products back end for the 16x16 multiplier.
// Products stream in over a valid/ready port and the final sum is returned over a second valid/ready port.
module product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [CNT_W-1:0]   remaining;
    logic [ACC_W:0]     sum_wide;
    logic               beat;

    // The extra top bit of the sum is the carry out of the accumulator width.
    function automatic logic [ACC_W:0] wide_add(input logic [ACC_W-1:0] a,
                                                input logic [PROD_W-1:0] p);
        return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
    endfunction

    function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W:0] s);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign sum_wide  = wide_add(acc, in_product);
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beat      = in_valid & in_ready;
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                        state     <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        // Once saturated, any further non-zero product carries out again, so acc stays all-ones.
                        acc       <= saturate(sum_wide);
                        ovf       <= ovf | sum_wide[ACC_W];
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized, self-checking bench for product_accumulator using a saturating-sum model.
// Built with ACC_W=33 so that saturation is reachable with a handful of 32-bit products.
module tb_product_accumulator;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 33;
    localparam int CNT_W  = 8;
    localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] prods[$];
    bit          pat[$];

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned running sum clamped at the accumulator maximum.
    function automatic logic [63:0] model_sum(output bit ovf);
        logic [63:0] s;
        s   = 64'd0;
        ovf = 1'b0;
        foreach (prods[i]) begin
            s = s + {32'd0, prods[i]};
            if (s > ACC_MAX) begin
                s   = ACC_MAX;
                ovf = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic do_start(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    // Offers prods[] using pat[] for in_valid (random at gap_pct when pat runs out).
    task automatic feed(input int gap_pct, output int cycles, output int ready_cycles, output bit ok);
        int idx;
        idx          = 0;
        cycles       = 0;
        ready_cycles = 0;
        while (idx < prods.size() && cycles < 2000) begin
            if (pat.size() > cycles) in_valid = pat[cycles];
            else in_valid = ($urandom_range(99) >= gap_pct);
            in_product = in_valid ? prods[idx] : $urandom;
            if (in_ready) ready_cycles++;
            if (in_valid && in_ready) idx++;
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        ok = (idx == prods.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000 || out_sum !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b ovf=%b sum=%h, want all zero",
                     in_ready, out_valid, busy, out_ovf, out_sum);
        end
        in_valid = 1'b1; in_product = 32'h1234_5678;
        repeat (3) tick();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000 || out_sum !== '0) begin
            errors++;
            $display("FAIL idle_ignores_valid: got rdy=%b vld=%b busy=%b ovf=%b sum=%h, want all zero",
                     in_ready, out_valid, busy, out_ovf, out_sum);
        end
    endtask

    task automatic test_basic();
        int cyc, rdy;
        bit ok;
        prods = '{32'd6, 32'hFFFE_0001, 32'd10};
        pat   = '{1, 1, 1};
        do_start(3);
        feed(0, cyc, rdy, ok);
        checks++;
        if (!ok || rdy != 3 || cyc != 3) begin
            errors++;
            $display("FAIL basic_ready_cycles: got ok=%0d ready=%0d cycles=%0d, want 1/3/3", ok, rdy, cyc);
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 33'h0_FFFE_0011 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: got vld=%b rdy=%b sum=%h ovf=%b, want 1 0 0fffe0011 0",
                     out_valid, in_ready, out_sum, out_ovf);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int cyc, rdy;
        bit ok;
        prods = '{32'd1, 32'd2, 32'd3, 32'd4};
        pat   = '{1, 0, 1, 1, 0, 1};
        do_start(4);
        feed(0, cyc, rdy, ok);
        checks++;
        if (!ok || cyc != 6) begin
            errors++;
            $display("FAIL stall_cycles: got ok=%0d cycles=%0d, want 1/6", ok, cyc);
        end
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); len = 8'd9;
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_sum !== 33'd10 || out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got vld=%b busy=%b sum=%0d ovf=%b, want 1 1 10 0",
                         i, out_valid, busy, out_sum, out_ovf);
            end
            tick();
        end
        start = 1'b0; len = '0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_sum !== 33'd10) begin
            errors++;
            $display("FAIL stall_to_idle: got vld=%b busy=%b rdy=%b sum=%0d, want 0 0 0 10",
                     out_valid, busy, in_ready, out_sum);
        end
    endtask

    task automatic test_back_to_back();
        do_start(0);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_sum !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL empty_sum: got vld=%b busy=%b rdy=%b sum=%h ovf=%b, want 1 1 0 0 0",
                     out_valid, busy, in_ready, out_sum, out_ovf);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        do_start(1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: got in_ready=%b, want 1", in_ready);
        end
        in_valid = 1'b1; in_product = 32'd7; tick(); in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 33'd7 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sum: got vld=%b sum=%0d ovf=%b, want 1 7 0", out_valid, out_sum, out_ovf);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        int cyc, rdy;
        bit ok;
        prods = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        pat   = '{1, 1, 1};
        do_start(3);
        feed(0, cyc, rdy, ok);
        checks++;
        if (!ok || out_valid !== 1'b1 || out_sum !== 33'h1_FFFF_FFFF || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_sum: got ok=%0d vld=%b sum=%h ovf=%b, want 1 1 1ffffffff 1",
                     ok, out_valid, out_sum, out_ovf);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        prods = '{32'd5};
        pat   = '{1};
        do_start(1);
        feed(0, cyc, rdy, ok);
        checks++;
        if (!ok || out_sum !== 33'd5 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got ok=%0d sum=%0d ovf=%b, want 1 5 0", ok, out_sum, out_ovf);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc, rdy;
        bit ok;
        do_start(5);
        in_valid = 1'b1; in_product = 32'd100; tick(); tick();
        in_valid = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000 || out_sum !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b ovf=%b sum=%h, want all zero",
                     in_ready, out_valid, busy, out_ovf, out_sum);
        end
        prods = '{32'd3, 32'd4};
        pat   = '{1, 1};
        do_start(2);
        feed(0, cyc, rdy, ok);
        checks++;
        if (!ok || out_valid !== 1'b1 || out_sum !== 33'd7) begin
            errors++;
            $display("FAIL reset_mid_rerun: got ok=%0d vld=%b sum=%0d, want 1 1 7", ok, out_valid, out_sum);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_random();
        int cyc, rdy, n, wait_n;
        bit ok, ovf_exp;
        logic [63:0] sum_exp;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(12);
            prods.delete();
            pat.delete();
            for (int i = 0; i < n; i++)
                prods.push_back(($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(5000)));
            sum_exp = model_sum(ovf_exp);
            do_start(n);
            feed(30, cyc, rdy, ok);
            checks++;
            if (!ok || out_valid !== 1'b1 || {31'd0, out_sum} !== sum_exp || out_ovf !== ovf_exp) begin
                errors++;
                $display("FAIL random_run[%0d] len=%0d: got ok=%0d vld=%b sum=%h ovf=%b, want 1 1 %h %b",
                         r, n, ok, out_valid, out_sum, out_ovf, sum_exp[ACC_W-1:0], ovf_exp);
            end
            wait_n = $urandom_range(3);
            repeat (wait_n) tick();
            checks++;
            if (out_valid !== 1'b1 || {31'd0, out_sum} !== sum_exp) begin
                errors++;
                $display("FAIL random_hold[%0d]: got vld=%b sum=%h, want 1 %h",
                         r, out_valid, out_sum, sum_exp[ACC_W-1:0]);
            end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_idle[%0d]: got busy=%b vld=%b, want 0 0", r, busy, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
